// File: rtl/uc_collector.sv
// Unit-clause collector: per-engine FIFOs served round-robin, with a seen-bitmap
// filter so each distinct nonzero literal reaches the arbiter at most once.

module uc_lane_fifo #(
  parameter int LIT_W = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [LIT_W-1:0] din,
  input  logic             pop,
  output logic [LIT_W-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [LIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr;

  // Full is judged on the registered count, so a pop in the same cycle does not make room.
  assign wr   = push && (count != CW'(DEPTH));
  assign head = mem[rd_ptr];

  always_ff @(posedge clk)
    if (wr && !flush) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end
endmodule

module uc_collector #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [NUM_ENG-1:0]       eng_push,
  input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
  output logic [NUM_ENG-1:0]       eng_full,
  output logic                     out_valid,
  output logic [LIT_W-1:0]         out_lit,
  output logic                     idle,
  output logic                     overflow,
  output logic [CNT_W-1:0]         dup_cnt
);
  localparam int PW   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int MAGS = 2 ** (LIT_W - 1);

  logic                           flush;
  logic [NUM_ENG-1:0][LIT_W-1:0]  head;
  logic [NUM_ENG-1:0][CW-1:0]     cnt;
  logic [NUM_ENG-1:0]             nonempty, pop;
  logic [PW-1:0]                  rr_ptr, rr_nxt, gnt_idx, idx;
  logic                           gnt_any;
  logic [LIT_W-1:0]               hd, neg;
  logic                           pol, hit;
  logic [LIT_W-2:0]               mag;
  logic [MAGS-1:0]                seen_p, seen_n;

  assign flush = rst | clear;

  for (genvar i = 0; i < NUM_ENG; i++) begin : g_lane
    uc_lane_fifo #(.LIT_W(LIT_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .flush (flush),
      .push  (eng_push[i]),
      .din   (eng_lit[i*LIT_W +: LIT_W]),
      .pop   (pop[i]),
      .head  (head[i]),
      .count (cnt[i])
    );
    assign nonempty[i] = (cnt[i] != '0);
    assign eng_full[i] = (cnt[i] == CW'(DEPTH));
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    pop     = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_ENG);
      if (!gnt_any && nonempty[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) pop[gnt_idx] = 1'b1;
    rr_nxt = (gnt_idx == PW'(NUM_ENG - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Negative literals index the bitmap by magnitude; the most-negative code folds to 0.
  always_comb begin
    hd  = head[gnt_idx];
    pol = hd[LIT_W-1];
    neg = -hd;
    mag = pol ? neg[LIT_W-2:0] : hd[LIT_W-2:0];
    hit = pol ? seen_n[mag] : seen_p[mag];
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rr_ptr    <= '0;
      seen_p    <= '0;
      seen_n    <= '0;
      out_valid <= 1'b0;
      out_lit   <= '0;
      overflow  <= 1'b0;
      dup_cnt   <= '0;
    end else begin
      if (|(eng_push & eng_full)) overflow <= 1'b1;
      out_valid <= 1'b0;
      if (gnt_any) begin
        rr_ptr <= rr_nxt;
        if (mag != '0) begin
          if (hit) begin
            if (dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
          end else begin
            if (pol) seen_n[mag] <= 1'b1;
            else     seen_p[mag] <= 1'b1;
            out_valid <= 1'b1;
            out_lit   <= hd;
          end
        end
      end
    end
  end

  assign idle = ~|nonempty & ~out_valid;
endmodule

// File: tb/tb_uc_collector.sv
// Directed bench: stimulus queues expected literals, a negedge monitor checks them.
module tb_uc_collector;
  logic        clk = 1'b0;
  logic        rst, clear;
  logic [3:0]  eng_push;
  logic [31:0] eng_lit;
  logic [3:0]  eng_full;
  logic        out_valid, idle, overflow;
  logic [7:0]  out_lit;
  logic [15:0] dup_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uc_collector #(.NUM_ENG(4), .LIT_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .eng_push(eng_push), .eng_lit(eng_lit),
    .eng_full(eng_full), .out_valid(out_valid), .out_lit(out_lit), .idle(idle),
    .overflow(overflow), .dup_cnt(dup_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_lit unexpected: got %0h, none expected", out_lit);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_lit !== e) begin
          errors++;
          $display("FAIL out_lit: got %0h, expected %0h", out_lit, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [7:0] l0, l1, l2, l3);
    eng_push = m;
    eng_lit  = {l3, l2, l1, l0};
    step();
    eng_push = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!idle && n < 40) begin
      step();
      n++;
    end
    chk({name, " idle"}, idle, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; eng_push = '0; eng_lit = '0;
    step(); step();
    rst = 1'b0;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_lit", out_lit, 0);
    chk("rst idle", idle, 1);
    chk("rst overflow", overflow, 0);
    chk("rst dup_cnt", dup_cnt, 0);
    chk("rst eng_full", eng_full, 0);

    // 1: single literal, 2-cycle latency
    exp_q.push_back(8'd5);
    drive(4'b0001, 8'd5, 0, 0, 0);
    chk("t1 idle c2", idle, 0);
    step();
    chk("t1 idle c3", idle, 0);
    chk("t1 valid c3", out_valid, 1);
    step();
    chk("t1 idle c4", idle, 1);

    // 2: round-robin from rr=0 then rr=2
    exp_q.push_back(8'd100);
    drive(4'b1000, 0, 0, 0, 8'd100);
    wait_idle("t2a");
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd3); exp_q.push_back(8'd4);
    drive(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4);
    wait_idle("t2b");
    exp_q.push_back(8'd20);
    drive(4'b0010, 0, 8'd20, 0, 0);
    wait_idle("t2c");
    exp_q.push_back(8'd11); exp_q.push_back(8'd12);
    exp_q.push_back(8'd9);  exp_q.push_back(8'd10);
    drive(4'b1111, 8'd9, 8'd10, 8'd11, 8'd12);
    wait_idle("t2d");
    chk("t2 queue drained", exp_q.size(), 0);

    // 3: duplicate dropped, opposite polarity forwarded
    exp_q.push_back(8'd7); exp_q.push_back(8'hF9);
    drive(4'b0010, 0, 8'd7, 0, 0);
    drive(4'b0010, 0, 8'd7, 0, 0);
    drive(4'b0010, 0, 8'hF9, 0, 0);
    wait_idle("t3");
    chk("t3 dup_cnt", dup_cnt, 1);

    // 4: lane2 fills while lanes 3,0,1 take grants; 5th push dropped
    exp_q.push_back(8'd50);
    drive(4'b0100, 0, 0, 8'd50, 0);
    wait_idle("t4a");
    exp_q.push_back(8'd33); exp_q.push_back(8'd30); exp_q.push_back(8'd31);
    exp_q.push_back(8'd40); exp_q.push_back(8'd41); exp_q.push_back(8'd42);
    exp_q.push_back(8'd43);
    drive(4'b1111, 8'd30, 8'd31, 8'd40, 8'd33);
    chk("t4 overflow early", overflow, 0);
    drive(4'b0100, 0, 0, 8'd41, 0);
    drive(4'b0100, 0, 0, 8'd42, 0);
    drive(4'b0100, 0, 0, 8'd43, 0);
    chk("t4 eng_full", eng_full, 4'b0100);
    drive(4'b0100, 0, 0, 8'd44, 0);
    chk("t4 overflow", overflow, 1);
    chk("t4 eng_full after", eng_full, 0);
    wait_idle("t4b");
    chk("t4 overflow sticky", overflow, 1);

    // 5: zero and most-negative code are discarded silently
    drive(4'b0011, 8'h00, 8'h80, 0, 0);
    wait_idle("t5");
    chk("t5 dup_cnt", dup_cnt, 1);
    chk("t5 overflow", overflow, 1);

    // 6: clear with 3 buffered, then previously seen literals pass again
    drive(4'b0111, 8'd60, 8'd61, 8'd62, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6 idle", idle, 1);
    chk("t6 out_valid", out_valid, 0);
    chk("t6 dup_cnt", dup_cnt, 0);
    chk("t6 overflow", overflow, 0);
    chk("t6 eng_full", eng_full, 0);
    exp_q.push_back(8'd5); exp_q.push_back(8'd7);
    drive(4'b0011, 8'd5, 8'd7, 0, 0);
    wait_idle("t6b");
    step();
    chk("final queue drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
